// File: rtl/shift_ram_buffer_cnt_pkg.sv
// Shared constants and helpers for the RAM-based delay line.
package shift_ram_buffer_cnt_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 256;

  // Pointer width never collapses to zero bits, even for DEPTH <= 2.
  function automatic int ptr_w(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/sdp_ram_rf.sv
// Synchronous read-first RAM: one shared address, old contents appear on dout.
module sdp_ram_rf
  import shift_ram_buffer_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (en) begin
      dout_q     <= mem[addr];
      mem[addr]  <= din;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/shift_ram_buffer_cnt.sv
// Fixed DEPTH-stage, clock-enabled delay line built on a circular RAM buffer.
module shift_ram_buffer_cnt
  import shift_ram_buffer_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    fill_cnt_q, fill_cnt_d;
  logic             q_vld_q, q_vld_d;
  logic             primed;
  logic [WIDTH-1:0] ram_dout;

  always_comb begin
    primed     = (fill_cnt_q == CNT_FULL);
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    q_vld_d    = q_vld_q;
    if (ce) begin
      wr_ptr_d   = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      fill_cnt_d = primed ? fill_cnt_q : fill_cnt_q + CW'(1);
      q_vld_d    = primed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      q_vld_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      q_vld_q    <= q_vld_d;
    end
  end

  sdp_ram_rf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk  (clk),
    .en   (ce),
    .addr (wr_ptr_q),
    .din  (d),
    .dout (ram_dout)
  );

  // The RAM output register is the q register; the resettable valid flag
  // masks stale memory contents so q reads 0 immediately on reset and until primed.
  assign q = q_vld_q ? ram_dout : '0;

endmodule

// File: tb/tb_shift_ram_buffer_cnt.sv
// Directed bench for shift_ram_buffer_cnt at DEPTH=256/WIDTH=64 and DEPTH=2/WIDTH=8.
module tb_shift_ram_buffer_cnt;

  logic        clk;
  logic        rst_n;
  logic        ce;
  logic [63:0] d;
  logic [63:0] q;
  logic        ce2;
  logic [7:0]  d2;
  logic [7:0]  q2;

  logic [63:0] hist [$];
  logic [63:0] exp_q;
  int          n_cmp;
  int          n_err;

  shift_ram_buffer_cnt #(.WIDTH(64), .DEPTH(256)) u_big (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .d     (d),
    .q     (q)
  );

  shift_ram_buffer_cnt #(.WIDTH(8), .DEPTH(2)) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce2),
    .d     (d2),
    .q     (q2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge on the big instance; the queue holds every word written since reset.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ce) begin
      hist.push_back(d);
      if (hist.size() > 256) exp_q = hist[hist.size() - 257];
      else                   exp_q = 64'd0;
    end
    chk("q_model", q, exp_q);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_q = 64'd0;
    rst_n = 1'b0;
    ce    = 1'b0;
    d     = 64'd0;
    ce2   = 1'b0;
    d2    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q_big", q, 64'd0);
    chk("reset_q_small", {56'd0, q2}, 64'd0);
    rst_n = 1'b1;

    // Small DEPTH=2 instance: 1,2,3,4,5 -> 0,0,1,2,3, then hold on ce=0.
    ce2 = 1'b1;
    d2 = 8'd1; tick(); chk("small_e1", {56'd0, q2}, 64'd0);
    d2 = 8'd2; tick(); chk("small_e2", {56'd0, q2}, 64'd0);
    d2 = 8'd3; tick(); chk("small_e3", {56'd0, q2}, 64'd1);
    d2 = 8'd4; tick(); chk("small_e4", {56'd0, q2}, 64'd2);
    d2 = 8'd5; tick(); chk("small_e5", {56'd0, q2}, 64'd3);
    ce2 = 1'b0; d2 = 8'd99;
    tick(); chk("small_hold", {56'd0, q2}, 64'd3);

    // Ramp from reset.
    ce = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      d = 64'(100 + k - 1);
      tick();
      if (k == 1)   chk("ramp_e1", q, 64'd0);
      if (k == 256) chk("ramp_e256", q, 64'd0);
      if (k == 257) chk("ramp_e257", q, 64'd100);
      if (k == 258) chk("ramp_e258", q, 64'd101);
      if (k == 300) chk("ramp_e300", q, 64'd143);
    end

    // Enable gating on a primed buffer.
    for (int i = 0; i < 20; i++) begin
      ce = (i % 2 == 0);
      d  = 64'(200 + i);
      tick();
      if (i == 0) chk("gate_e301", q, 64'd144);
      if (i == 1) chk("gate_hold", q, 64'd144);
      if (i == 2) chk("gate_e302", q, 64'd145);
    end

    // Pause: idle cycles must not age the stored word.
    ce = 1'b1; d = 64'hDEAD_BEEF;
    tick();
    ce = 1'b0; d = 64'h5555;
    repeat (256) tick();
    ce = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = 64'(500 + i);
      tick();
    end
    chk("pause_deadbeef", q, 64'hDEAD_BEEF);

    // Wrap through the pointer boundary several times.
    for (int j = 1; j <= 266; j++) begin
      d = 64'(300 + j - 1);
      tick();
      if (j > 256) chk("wrap", q, 64'(300 + j - 257));
    end

    // Mid-stream reset after 100 writes.
    for (int i = 0; i < 100; i++) begin
      d = 64'(600 + i);
      tick();
    end
    rst_n = 1'b0;
    ce    = 1'b0;
    hist.delete();
    exp_q = 64'd0;
    #1;
    chk("rst_async_q", q, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    ce    = 1'b1;
    for (int j = 1; j <= 258; j++) begin
      d = 64'(700 + j - 1);
      tick();
      if (j == 256) chk("post_rst_e256", q, 64'd0);
      if (j == 257) chk("post_rst_e257", q, 64'd700);
      if (j == 258) chk("post_rst_e258", q, 64'd701);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
